// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for the sequential magnitude comparator.
// The requester drives operands and start. The comparator returns busy, done and the result flags.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, a_gt_b, a_lt_b, a_eq_b
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. It walks two WIDTH-bit operands MSB-first,
// DIGIT bits per clock. Signed compares are handled by flipping both operand
// MSBs at load time (offset binary), so the datapath itself is always unsigned.
module seq_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    seq_magnitude_comparator_if.slave        bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK   = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             decided_q, gt_q, lt_q;
    logic             done_q, flag_gt_q, flag_lt_q, flag_eq_q;

    logic [DIGIT-1:0] top_a, top_b;
    logic             digit_diff, new_gt, new_lt, finish, accept;

    // Current digit decode and the decision that results once this digit is included
    always_comb begin
        top_a      = sh_a_q[WIDTH-1 -: DIGIT];
        top_b      = sh_b_q[WIDTH-1 -: DIGIT];
        digit_diff = (top_a != top_b);
        new_gt     = decided_q ? gt_q : (top_a > top_b);
        new_lt     = decided_q ? lt_q : (top_a < top_b);
        accept     = (state_q == IDLE) && bus.start;
        finish     = (state_q == COMPARE) &&
                     ((cnt_q == LAST_DIGIT) || (EARLY_EXIT && !decided_q && digit_diff));
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: a default assignment on entry prevents latch inference on paths that do not assign.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = COMPARE;
            COMPARE: if (finish)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand shift registers, digit counter, frozen decision and result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shift registers are ordinary flops, so they are cleared here along with the control state.
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            done_q    <= 1'b0;
            flag_gt_q <= 1'b0;
            flag_lt_q <= 1'b0;
            flag_eq_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                sh_a_q    <= bus.signed_mode ? (bus.a ^ MSB_MASK) : bus.a;
                sh_b_q    <= bus.signed_mode ? (bus.b ^ MSB_MASK) : bus.b;
                cnt_q     <= '0;
                decided_q <= 1'b0;
                gt_q      <= 1'b0;
                lt_q      <= 1'b0;
            end else if (state_q == COMPARE) begin
                sh_a_q <= sh_a_q << DIGIT;
                sh_b_q <= sh_b_q << DIGIT;
                cnt_q  <= cnt_q + CNT_W'(1);
                // The first differing digit decides the result; later digits are ignored
                if (!decided_q && digit_diff) begin
                    decided_q <= 1'b1;
                    gt_q      <= new_gt;
                    lt_q      <= new_lt;
                end
                if (finish) begin
                    done_q    <= 1'b1;
                    flag_gt_q <= new_gt;
                    flag_lt_q <= new_lt;
                    flag_eq_q <= !new_gt && !new_lt;
                end
            end
        end
    end

    // Output decode
    always_comb begin
        bus.busy   = (state_q == COMPARE);
        bus.done   = done_q;
        bus.a_gt_b = flag_gt_q;
        bus.a_lt_b = flag_lt_q;
        bus.a_eq_b = flag_eq_q;
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator. It covers fixed-latency mode (8/2),
// early exit (8/2), and early exit on a wide-digit variant (16/4).
module tb_seq_magnitude_comparator;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   lat, busy_n, done_n, hold_bad;

    seq_magnitude_comparator_if #(.WIDTH(8))  i0 ();
    seq_magnitude_comparator_if #(.WIDTH(8))  i1 ();
    seq_magnitude_comparator_if #(.WIDTH(16)) i2 ();

    seq_magnitude_comparator #(.WIDTH(8),  .DIGIT(2), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    seq_magnitude_comparator #(.WIDTH(8),  .DIGIT(2), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge on dut0 and counts edges until done (lat) and busy cycles
    task automatic run0(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                        output int l, output int bn);
        l = -1; bn = 0;
        @(negedge clk);
        i0.a = av; i0.b = bv; i0.signed_mode = sm; i0.start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            i0.start = 1'b0;
            if (i0.busy) bn++;
            if (i0.done) begin l = i - 1; break; end
        end
    endtask

    task automatic run1(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                        output int l, output int bn);
        l = -1; bn = 0;
        @(negedge clk);
        i1.a = av; i1.b = bv; i1.signed_mode = sm; i1.start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            i1.start = 1'b0;
            if (i1.busy) bn++;
            if (i1.done) begin l = i - 1; break; end
        end
    endtask

    task automatic run2(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                        output int l, output int bn);
        l = -1; bn = 0;
        @(negedge clk);
        i2.a = av; i2.b = bv; i2.signed_mode = sm; i2.start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            i2.start = 1'b0;
            if (i2.busy) bn++;
            if (i2.done) begin l = i - 1; break; end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i0.start = 1'b0; i0.a = '0; i0.b = '0; i0.signed_mode = 1'b0;
        i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.signed_mode = 1'b0;
        i2.start = 1'b0; i2.a = '0; i2.b = '0; i2.signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_busy",  i0.busy, 0);
        check("rst_done",  i0.done, 0);
        check("rst_flags", {i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, 3'b000);
        check("rst_flags_e16", {i2.a_gt_b, i2.a_lt_b, i2.a_eq_b}, 3'b000);

        // 1: unsigned 0x01 < 0x02, fixed latency of 4
        run0(8'h01, 8'h02, 1'b0, lat, busy_n);
        check("t1_lat",   lat, 4);
        check("t1_busy",  busy_n, 4);
        check("t1_flags", {i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, 3'b010);
        @(negedge clk);
        check("t1_done_one_cycle", i0.done, 0);

        // 2: signed versus unsigned interpretation
        run0(8'hFF, 8'h01, 1'b1, lat, busy_n);
        check("t2_s_ff_01", {lat[3:0], i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, {4'd4, 3'b010});
        run0(8'hFF, 8'h01, 1'b0, lat, busy_n);
        check("t2_u_ff_01", {lat[3:0], i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, {4'd4, 3'b100});
        run0(8'h80, 8'h7F, 1'b1, lat, busy_n);
        check("t2_s_80_7f", {lat[3:0], i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, {4'd4, 3'b010});
        // Fixed mode keeps full latency even when the top digit already differs
        run0(8'h80, 8'h00, 1'b0, lat, busy_n);
        check("t2_fixed_lat", {lat[3:0], i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, {4'd4, 3'b100});

        // 3: equality in both modes, then flags hold through idle cycles
        run0(8'hA5, 8'hA5, 1'b0, lat, busy_n);
        check("t3_u_eq", {lat[3:0], i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, {4'd4, 3'b001});
        run0(8'hA5, 8'hA5, 1'b1, lat, busy_n);
        check("t3_s_eq", {lat[3:0], i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, {4'd4, 3'b001});
        done_n = 0; hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i0.done) done_n++;
            if ({i0.a_gt_b, i0.a_lt_b, i0.a_eq_b} !== 3'b001) hold_bad++;
        end
        check("t3_hold_done", done_n, 0);
        check("t3_hold_flags", hold_bad, 0);

        // 4: start held high while operands toggle; restart in the done cycle
        @(negedge clk);
        i0.a = 8'h30; i0.b = 8'h10; i0.signed_mode = 1'b0; i0.start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i0.done) begin lat = i - 1; break; end
            i0.a = ~i0.a; i0.b = ~i0.b; i0.signed_mode = ~i0.signed_mode;
        end
        check("t4_held_lat", lat, 4);
        check("t4_held_flags", {i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, 3'b100);
        check("t4_done_cycle_idle", i0.busy, 0);
        i0.a = 8'h10; i0.b = 8'h20; i0.signed_mode = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            i0.start = 1'b0;
            if (i == 1) begin
                check("t4_b2b_accepted", i0.busy, 1);
                check("t4_flags_kept", {i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, 3'b100);
            end
            if (i0.done) begin lat = i - 1; break; end
        end
        check("t4_b2b_lat", lat, 4);
        check("t4_b2b_flags", {i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, 3'b010);

        // 5: reset during the second COMPARE cycle aborts the compare
        @(negedge clk);
        i0.a = 8'h55; i0.b = 8'h11; i0.start = 1'b1;
        @(negedge clk);
        i0.start = 1'b0;
        @(negedge clk);
        check("t5_busy_before_rst", i0.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy_after_rst", i0.busy, 0);
        check("t5_flags_after_rst", {i0.a_gt_b, i0.a_lt_b, i0.a_eq_b}, 3'b000);
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i0.done) done_n++;
        end
        check("t5_no_done", done_n, 0);

        // 6: early exit variants
        run1(8'h80, 8'h00, 1'b0, lat, busy_n);
        check("t6_e_80_00_lat", lat, 1);
        check("t6_e_80_00_busy", busy_n, 1);
        check("t6_e_80_00_flags", {i1.a_gt_b, i1.a_lt_b, i1.a_eq_b}, 3'b100);
        run1(8'h81, 8'h80, 1'b0, lat, busy_n);
        check("t6_e_81_80", {lat[3:0], i1.a_gt_b, i1.a_lt_b, i1.a_eq_b}, {4'd4, 3'b100});
        run1(8'h7F, 8'h80, 1'b1, lat, busy_n);
        check("t6_e_s_7f_80", {lat[3:0], i1.a_gt_b, i1.a_lt_b, i1.a_eq_b}, {4'd1, 3'b100});
        run2(16'h1234, 16'h1234, 1'b0, lat, busy_n);
        check("t6_e16_eq", {lat[3:0], i2.a_gt_b, i2.a_lt_b, i2.a_eq_b}, {4'd4, 3'b001});
        run2(16'h1234, 16'h1334, 1'b0, lat, busy_n);
        check("t6_e16_lt", {lat[3:0], i2.a_gt_b, i2.a_lt_b, i2.a_eq_b}, {4'd2, 3'b010});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
